issue_regread: RTL and testbench

Register-read stage on the consumer side of the integer issue queue. Each cycle it takes the issue queue's selected entries, allocates a limited pool of regfile read ports to their sources, and returns per-lane finished/replay feedback with the entry index. Granted lanes get operands from the synchronous regfile one cycle later; the stage forwards operands and `exeInfo_t` to the functional units, holding them under FU backpressure.

---
 rtl/issue_regread.sv | 161 ++++++++++++++++
 tb/tb_issue_regread.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_regread.sv
// Register-read stage behind the integer issue queue: shares a small pool of regfile
// read ports among the selected lanes, then presents operands to the FUs one cycle later.
module issue_regread #(
  parameter int INOUTPORT_NUM = 2,
  parameter int DEPTH         = 8,
  parameter int RFREAD_PORTS  = 3,
  parameter int XLEN          = 64,
  parameter int NUMSRCS_INT   = 2,
  parameter int IPR_W         = 6,
  parameter int EXE_W         = 32,
  localparam int IDX_W        = $clog2(DEPTH),
  localparam int PORT_W       = (RFREAD_PORTS > 1) ? $clog2(RFREAD_PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic [INOUTPORT_NUM-1:0] i_can_issue,
  input  logic [IDX_W-1:0]         i_issue_idx [INOUTPORT_NUM],
  input  logic [EXE_W-1:0]         i_issue_exeInfo [INOUTPORT_NUM],
  output logic                     o_stall,
  output logic [INOUTPORT_NUM-1:0] o_issue_finished_vec,
  output logic [INOUTPORT_NUM-1:0] o_issue_replay_vec,
  output logic [IDX_W-1:0]         o_feedback_idx [INOUTPORT_NUM],
  output logic [RFREAD_PORTS-1:0]  o_rf_rd_vld,
  output logic [IPR_W-1:0]         o_rf_rd_idx [RFREAD_PORTS],
  input  logic [XLEN-1:0]          i_rf_rd_data [RFREAD_PORTS],
  output logic [INOUTPORT_NUM-1:0] o_fu_vld,
  output logic [EXE_W-1:0]         o_fu_info [INOUTPORT_NUM],
  output logic [XLEN-1:0]          o_fu_srcs [INOUTPORT_NUM][NUMSRCS_INT],
  input  logic [INOUTPORT_NUM-1:0] i_fu_ready
);
  // exeInfo layout: source s physical index lives in bits [s*IPR_W +: IPR_W].
  // Handshake: an S1 lane is offered while o_fu_vld=1 and is consumed in any cycle
  // where i_fu_ready=1 for that lane; until then its operands are held stable.

  logic                     s0_en;
  logic [INOUTPORT_NUM-1:0] grant;
  logic [RFREAD_PORTS-1:0]  free_all, free_lane, tmp_vld;
  logic [IPR_W-1:0]         tmp_idx [RFREAD_PORTS];
  logic [PORT_W-1:0]        lane_port [INOUTPORT_NUM][NUMSRCS_INT];
  logic [IPR_W-1:0]         src_idx;
  logic                     lane_ok, found;
  int                       n_alloc;

  logic [INOUTPORT_NUM-1:0] vld_q, held_q;
  logic [EXE_W-1:0]         info_q [INOUTPORT_NUM];
  logic [PORT_W-1:0]        port_q [INOUTPORT_NUM][NUMSRCS_INT];
  logic [NUMSRCS_INT-1:0]   zero_q [INOUTPORT_NUM];
  logic [XLEN-1:0]          hold_q [INOUTPORT_NUM][NUMSRCS_INT];
  logic [XLEN-1:0]          op_mux [INOUTPORT_NUM][NUMSRCS_INT];

  assign o_stall = |(vld_q & ~i_fu_ready);
  assign s0_en   = !rst && !i_flush && !o_stall;

  // Each lane tries against a scratch copy of the free mask and only commits it when
  // every needed source found a port, so a failed lane leaves ports for later lanes.
  always_comb begin
    grant       = '0;
    free_all    = '1;
    free_lane   = '1;
    tmp_vld     = '0;
    src_idx     = '0;
    lane_ok     = 1'b0;
    found       = 1'b0;
    n_alloc     = 0;
    o_rf_rd_vld = '0;
    for (int p = 0; p < RFREAD_PORTS; p++) begin
      o_rf_rd_idx[p] = '0;
      tmp_idx[p]     = '0;
    end
    for (int l = 0; l < INOUTPORT_NUM; l++)
      for (int s = 0; s < NUMSRCS_INT; s++)
        lane_port[l][s] = '0;
    for (int l = 0; l < INOUTPORT_NUM; l++) begin
      free_lane = free_all;
      tmp_vld   = '0;
      lane_ok   = s0_en && i_can_issue[l];
      for (int s = 0; s < NUMSRCS_INT; s++) begin
        src_idx = i_issue_exeInfo[l][s*IPR_W +: IPR_W];
        found   = 1'b0;
        if (src_idx != '0) begin
          for (int p = 0; p < RFREAD_PORTS; p++) begin
            if (!found && free_lane[p]) begin
              found           = 1'b1;
              free_lane[p]    = 1'b0;
              tmp_vld[p]      = 1'b1;
              tmp_idx[p]      = src_idx;
              lane_port[l][s] = PORT_W'(p);
            end
          end
          if (!found) lane_ok = 1'b0;
        end
      end
      if (lane_ok) begin
        grant[l]    = 1'b1;
        free_all    = free_lane;
        o_rf_rd_vld = o_rf_rd_vld | tmp_vld;
        n_alloc     = n_alloc + $countones(tmp_vld);
        for (int p = 0; p < RFREAD_PORTS; p++)
          if (tmp_vld[p]) o_rf_rd_idx[p] = tmp_idx[p];
      end
    end
  end

  assign o_issue_finished_vec = grant;
  assign o_issue_replay_vec   = {INOUTPORT_NUM{s0_en}} & i_can_issue & ~grant;
  assign o_feedback_idx       = i_issue_idx;

  always_comb begin
    for (int l = 0; l < INOUTPORT_NUM; l++)
      for (int s = 0; s < NUMSRCS_INT; s++) begin
        op_mux[l][s]    = zero_q[l][s] ? '0 : i_rf_rd_data[port_q[l][s]];
        o_fu_srcs[l][s] = held_q[l] ? hold_q[l][s] : op_mux[l][s];
      end
  end

  assign o_fu_vld  = vld_q;
  assign o_fu_info = info_q;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      vld_q  <= '0;
      held_q <= '0;
    end else begin
      for (int l = 0; l < INOUTPORT_NUM; l++) begin
        if (grant[l]) begin
          vld_q[l]  <= 1'b1;
          held_q[l] <= 1'b0;
        end else if (i_fu_ready[l]) begin
          vld_q[l]  <= 1'b0;
          held_q[l] <= 1'b0;
        end else if (vld_q[l]) begin
          held_q[l] <= 1'b1;
        end
      end
    end
  end

  // Payload and hold registers carry no reset; they are qualified by vld_q / held_q.
  always_ff @(posedge clk) begin
    for (int l = 0; l < INOUTPORT_NUM; l++) begin
      if (grant[l]) begin
        info_q[l] <= i_issue_exeInfo[l];
        for (int s = 0; s < NUMSRCS_INT; s++) begin
          port_q[l][s] <= lane_port[l][s];
          zero_q[l][s] <= (i_issue_exeInfo[l][s*IPR_W +: IPR_W] == '0);
        end
      end
      if (vld_q[l] && !i_fu_ready[l] && !held_q[l])
        for (int s = 0; s < NUMSRCS_INT; s++)
          hold_q[l][s] <= op_mux[l][s];
    end
  end

  a_fin_rep_excl: assert property (@(posedge clk) disable iff (rst)
    (o_issue_finished_vec & o_issue_replay_vec) == '0);
  a_port_budget: assert property (@(posedge clk) disable iff (rst)
    n_alloc <= RFREAD_PORTS);
  a_no_fb_stall: assert property (@(posedge clk) disable iff (rst)
    o_stall |-> (o_issue_finished_vec == '0 && o_issue_replay_vec == '0));
endmodule

// File: tb/tb_issue_regread.sv
// Bench for issue_regread: a 3-port and a 2-port instance share issue inputs; vector
// table, directed multi-cycle sequences, then random traffic against a port-budget model.
module tb_issue_regread;
  localparam int L = 2, S = 2, XL = 64, IW = 6, EW = 32, DW = 3;

  logic clk = 1'b0;
  logic rst, flush;
  logic [L-1:0] can, rdy, rdy2;
  logic [DW-1:0] iidx [L];
  logic [EW-1:0] info [L];
  logic rf_rand1, rf_rand2;

  logic stall1, stall2;
  logic [L-1:0] fin1, rep1, fuv1, fin2, rep2, fuv2;
  logic [DW-1:0] fbi1 [L];
  logic [DW-1:0] fbi2 [L];
  logic [2:0] rv1;
  logic [1:0] rv2;
  logic [IW-1:0] ri1 [3];
  logic [IW-1:0] ri2 [2];
  logic [XL-1:0] rd1 [3];
  logic [XL-1:0] rd2 [2];
  logic [EW-1:0] fi1 [L];
  logic [EW-1:0] fi2 [L];
  logic [XL-1:0] fs1 [L][S];
  logic [XL-1:0] fs2 [L][S];

  int n_chk = 0, n_fail = 0;

  issue_regread #(.RFREAD_PORTS(3)) u_dut1 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_can_issue(can), .i_issue_idx(iidx),
    .i_issue_exeInfo(info), .o_stall(stall1), .o_issue_finished_vec(fin1),
    .o_issue_replay_vec(rep1), .o_feedback_idx(fbi1), .o_rf_rd_vld(rv1), .o_rf_rd_idx(ri1),
    .i_rf_rd_data(rd1), .o_fu_vld(fuv1), .o_fu_info(fi1), .o_fu_srcs(fs1), .i_fu_ready(rdy));

  issue_regread #(.RFREAD_PORTS(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_can_issue(can), .i_issue_idx(iidx),
    .i_issue_exeInfo(info), .o_stall(stall2), .o_issue_finished_vec(fin2),
    .o_issue_replay_vec(rep2), .o_feedback_idx(fbi2), .o_rf_rd_vld(rv2), .o_rf_rd_idx(ri2),
    .i_rf_rd_data(rd2), .o_fu_vld(fuv2), .o_fu_info(fi2), .o_fu_srcs(fs2), .i_fu_ready(rdy2));

  // ---------------- clock / regfile models ----------------
  always #5 clk = ~clk;

  function automatic logic [63:0] regval(input logic [5:0] r);
    return {16'hBEEF, 10'd0, r, 26'd0, r};
  endfunction

  always @(posedge clk) begin
    for (int p = 0; p < 3; p++) rd1[p] <= rf_rand1 ? {$urandom, $urandom} : regval(ri1[p]);
    for (int p = 0; p < 2; p++) rd2[p] <= rf_rand2 ? {$urandom, $urandom} : regval(ri2[p]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_lanes(input logic [1:0] c, input logic [5:0] a0, a1, b0, b1);
    can     = c;
    info[0] = {20'h1A2B3, a1, a0};
    info[1] = {20'h4C5D6, b1, b0};
    iidx[0] = 3'd2;
    iidx[1] = 3'd5;
  endtask

  // Reference allocation: granted lanes take ports in scan order, packed from port 0.
  task automatic model_alloc(input int np, input logic st, output logic [1:0] fin,
                             output logic [1:0] rep, output logic [2:0] pv, output logic [17:0] pidx);
    int used, need;
    logic [5:0] sr;
    fin = '0; rep = '0; pv = '0; pidx = '0; used = 0;
    if (!rst && !flush && !st) begin
      for (int l = 0; l < L; l++) begin
        if (can[l]) begin
          need = 0;
          for (int s = 0; s < S; s++) if (info[l][s*IW +: IW] != 0) need++;
          if (used + need <= np) begin
            fin[l] = 1'b1;
            for (int s = 0; s < S; s++) begin
              sr = info[l][s*IW +: IW];
              if (sr != 0) begin
                pv[used] = 1'b1;
                pidx[used*IW +: IW] = sr;
                used++;
              end
            end
          end else rep[l] = 1'b1;
        end
      end
    end
  endtask

  typedef struct packed {
    logic            two;
    logic [1:0]      c;
    logic [3:0][5:0] s;
    logic [1:0]      fin;
    logic [1:0]      rep;
    logic [2:0]      pv;
    logic [2:0][5:0] pi;
  } vec_t;

  localparam int NV = 8;
  vec_t vt [NV];

  task automatic check_row(input vec_t v);
    if (v.two) begin
      chk("tbl_fin2", fin2, v.fin);
      chk("tbl_rep2", rep2, v.rep);
      chk("tbl_rv2", rv2, v.pv[1:0]);
      chk("tbl_ri2", {ri2[1], ri2[0]}, {v.pi[1], v.pi[0]});
    end else begin
      chk("tbl_fin1", fin1, v.fin);
      chk("tbl_rep1", rep1, v.rep);
      chk("tbl_rv1", rv1, v.pv);
      chk("tbl_ri1", {ri1[2], ri1[1], ri1[0]}, v.pi);
      chk("tbl_fbidx1", {fbi1[1], fbi1[0]}, {3'd5, 3'd2});
    end
  endtask

  task automatic check_fu_prev(input vec_t v);
    logic [5:0] sr;
    chk(v.two ? "tbl_fuv2" : "tbl_fuv1", v.two ? fuv2 : fuv1, v.fin);
    for (int l = 0; l < L; l++)
      if (v.fin[l])
        for (int s = 0; s < S; s++) begin
          sr = v.s[l*2+s];
          chk("tbl_src", v.two ? fs2[l][s] : fs1[l][s], (sr == 0) ? 64'd0 : regval(sr));
        end
  endtask

  // ---------------- reference model state (3-port / 2-port instance) ----------------
  logic [L-1:0]  m_vld, m2_vld;
  logic [EW-1:0] m_info [L];
  logic [XL-1:0] m_op [L][S];
  logic [XL-1:0] m2_op [L][S];

  initial begin
    logic m_stall;
    logic [1:0] e_fin1, e_rep1, e_fin2, e_rep2;
    logic [2:0] e_pv1, e_pv2;
    logic [17:0] e_pi1, e_pi2;
    logic [19:0] r20;
    logic [5:0] sa, sb;

    rst = 1'b1; flush = 1'b0; rdy = '1; rdy2 = '1; rf_rand1 = 1'b0; rf_rand2 = 1'b0;
    set_lanes(2'b00, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_fuv1", fuv1, 2'b00);
    chk("rst_stall1", stall1, 1'b0);
    chk("rst_fin1", fin1, 2'b00);
    chk("rst_rep1", rep1, 2'b00);
    chk("rst_rv1", rv1, 3'b000);
    chk("rst_fuv2", fuv2, 2'b00);

    // s packed as {lane1 src1, lane1 src0, lane0 src1, lane0 src0}; pi as {p2, p1, p0}
    vt[0] = '{two:0, c:2'b11, s:{6'd8, 6'd7, 6'd6, 6'd5},  fin:2'b01, rep:2'b10, pv:3'b011, pi:{6'd0, 6'd6, 6'd5}};
    vt[1] = '{two:0, c:2'b11, s:{6'd11, 6'd10, 6'd9, 6'd0}, fin:2'b11, rep:2'b00, pv:3'b111, pi:{6'd11, 6'd10, 6'd9}};
    vt[2] = '{two:1, c:2'b11, s:{6'd0, 6'd3, 6'd2, 6'd1},  fin:2'b01, rep:2'b10, pv:3'b011, pi:{6'd0, 6'd2, 6'd1}};
    vt[3] = '{two:1, c:2'b11, s:{6'd4, 6'd3, 6'd0, 6'd0},  fin:2'b11, rep:2'b00, pv:3'b011, pi:{6'd0, 6'd4, 6'd3}};
    vt[4] = '{two:0, c:2'b10, s:{6'd0, 6'd0, 6'd3, 6'd3},  fin:2'b10, rep:2'b00, pv:3'b000, pi:'0};
    vt[5] = '{two:0, c:2'b00, s:{6'd1, 6'd2, 6'd3, 6'd4},  fin:2'b00, rep:2'b00, pv:3'b000, pi:'0};
    vt[6] = '{two:0, c:2'b11, s:{6'd0, 6'd3, 6'd2, 6'd1},  fin:2'b11, rep:2'b00, pv:3'b111, pi:{6'd3, 6'd2, 6'd1}};
    vt[7] = '{two:1, c:2'b11, s:{6'd12, 6'd0, 6'd0, 6'd0}, fin:2'b11, rep:2'b00, pv:3'b001, pi:{6'd0, 6'd0, 6'd12}};

    for (int k = 0; k <= NV; k++) begin
      @(negedge clk);
      if (k < NV) set_lanes(vt[k].c, vt[k].s[0], vt[k].s[1], vt[k].s[2], vt[k].s[3]);
      else can = '0;
      #1;
      if (k > 0) check_fu_prev(vt[k-1]);
      if (k < NV) check_row(vt[k]);
    end

    // Backpressure: three stall cycles with scrambled regfile data, release on the fourth.
    @(negedge clk); set_lanes(2'b01, 5, 6, 0, 0); rdy = 2'b11; #1;
    chk("bp_grant", fin1, 2'b01);
    @(negedge clk); set_lanes(2'b11, 1, 2, 3, 4); rdy = 2'b00; rf_rand1 = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_stall", stall1, 1'b1);
      chk("bp_fin", fin1, 2'b00);
      chk("bp_rep", rep1, 2'b00);
      chk("bp_rv", rv1, 3'b000);
      chk("bp_fuv", fuv1, 2'b01);
      chk("bp_src0", fs1[0][0], regval(6'd5));
      chk("bp_src1", fs1[0][1], regval(6'd6));
      if (k < 2) begin @(negedge clk); #1; end
    end
    @(negedge clk); can = '0; rdy = 2'b11; #1;
    chk("bp_rel_stall", stall1, 1'b0);
    chk("bp_rel_fuv", fuv1, 2'b01);
    chk("bp_rel_src0", fs1[0][0], regval(6'd5));
    chk("bp_rel_src1", fs1[0][1], regval(6'd6));
    rf_rand1 = 1'b0;
    @(negedge clk); #1;
    chk("bp_after_fuv", fuv1, 2'b00);

    // Flush in the second stall cycle, then a flush without stall.
    @(negedge clk); set_lanes(2'b10, 0, 0, 7, 9); rdy = 2'b11; #1;
    chk("fl_grant", fin1, 2'b10);
    @(negedge clk); can = 2'b11; rdy = 2'b00; #1;
    chk("fl_stall", stall1, 1'b1);
    chk("fl_fuv", fuv1, 2'b10);
    @(negedge clk); flush = 1'b1; #1;
    chk("fl_fin", fin1, 2'b00);
    chk("fl_rv", rv1, 3'b000);
    @(negedge clk); flush = 1'b0; can = '0; #1;
    chk("fl_after_fuv", fuv1, 2'b00);
    chk("fl_after_stall", stall1, 1'b0);
    @(negedge clk); flush = 1'b1; can = 2'b11; rdy = 2'b11; #1;
    chk("fl_nostall_fin", fin1, 2'b00);
    chk("fl_nostall_rep", rep1, 2'b00);
    chk("fl_nostall_rv", rv1, 3'b000);
    @(negedge clk); flush = 1'b0; can = '0; #1;
    chk("fl_nostall_fuv", fuv1, 2'b00);

    // Reset while S1 holds a lane, then a clean issue.
    @(negedge clk); set_lanes(2'b01, 3, 4, 0, 0); rdy = 2'b11; #1;
    chk("rs_grant", fin1, 2'b01);
    @(negedge clk); rst = 1'b1; can = 2'b11; rdy = 2'b00; #1;
    chk("rs_fin", fin1, 2'b00);
    chk("rs_rep", rep1, 2'b00);
    @(negedge clk); rst = 1'b0; can = '0; rdy = 2'b11; #1;
    chk("rs_fuv", fuv1, 2'b00);
    chk("rs_stall", stall1, 1'b0);
    chk("rs_rv", rv1, 3'b000);
    @(negedge clk); set_lanes(2'b10, 0, 0, 12, 13); #1;
    chk("rs_new_fin", fin1, 2'b10);
    chk("rs_new_ports", {rv1, ri1[1], ri1[0]}, {3'b011, 6'd13, 6'd12});
    @(negedge clk); can = '0; #1;
    chk("rs_new_fuv", fuv1, 2'b10);
    chk("rs_new_info", fi1[1], {20'h4C5D6, 6'd13, 6'd12});
    chk("rs_new_src0", fs1[1][0], regval(6'd12));
    chk("rs_new_src1", fs1[1][1], regval(6'd13));

    // Random traffic against the reference model.
    @(negedge clk); rst = 1'b1; #1;
    m_vld = '0; m2_vld = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 60) == 0);
      flush = ($urandom_range(0, 25) == 0);
      can   = 2'($urandom);
      for (int l = 0; l < L; l++) begin
        rdy[l]  = ($urandom_range(0, 2) != 0);
        iidx[l] = 3'($urandom);
        sa      = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        sb      = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        r20     = 20'($urandom);
        info[l] = {r20, sb, sa};
      end
      m_stall = |(m_vld & ~rdy);
      model_alloc(3, m_stall, e_fin1, e_rep1, e_pv1, e_pi1);
      model_alloc(2, 1'b0, e_fin2, e_rep2, e_pv2, e_pi2);
      rf_rand1 = (e_fin1 == 2'b00);
      rf_rand2 = (e_fin2 == 2'b00);
      #1;
      chk("rnd_stall1", stall1, m_stall);
      chk("rnd_fin1", fin1, e_fin1);
      chk("rnd_rep1", rep1, e_rep1);
      chk("rnd_rv1", rv1, e_pv1);
      chk("rnd_ri1", {ri1[2], ri1[1], ri1[0]}, e_pi1);
      chk("rnd_fbidx1", {fbi1[1], fbi1[0]}, {iidx[1], iidx[0]});
      chk("rnd_fuv1", fuv1, m_vld);
      chk("rnd_stall2", stall2, 1'b0);
      chk("rnd_fin2", fin2, e_fin2);
      chk("rnd_rep2", rep2, e_rep2);
      chk("rnd_port2", {rv2, ri2[1], ri2[0]}, {e_pv2[1:0], e_pi2[11:0]});
      chk("rnd_fuv2", fuv2, m2_vld);
      for (int l = 0; l < L; l++) begin
        if (m_vld[l]) begin
          chk("rnd_info1", fi1[l], m_info[l]);
          for (int s = 0; s < S; s++) chk("rnd_src1", fs1[l][s], m_op[l][s]);
        end
        if (m2_vld[l])
          for (int s = 0; s < S; s++) chk("rnd_src2", fs2[l][s], m2_op[l][s]);
      end
      for (int l = 0; l < L; l++) begin
        if (rst || flush) begin
          m_vld[l] = 1'b0;
        end else if (e_fin1[l]) begin
          m_vld[l]  = 1'b1;
          m_info[l] = info[l];
          for (int s = 0; s < S; s++)
            m_op[l][s] = (info[l][s*IW +: IW] == 0) ? 64'd0 : regval(info[l][s*IW +: IW]);
        end else if (rdy[l]) begin
          m_vld[l] = 1'b0;
        end
        m2_vld[l] = e_fin2[l];
        for (int s = 0; s < S; s++)
          if (e_fin2[l])
            m2_op[l][s] = (info[l][s*IW +: IW] == 0) ? 64'd0 : regval(info[l][s*IW +: IW]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
